// File: rtl/compresor_inmediato_pkg.sv
// Shared widths, FSM state encodings and the short-form placement helper
// used by the immediate compressor and its splitter.
package compresor_inmediato_pkg;

  localparam int SHORT_W = 12;
  localparam int LONG_W  = 20;
  localparam int DATA_W  = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ONE  = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_LO   = 2'd3;

  // The extender reads the short form from the top bits of Inm, so pad below.
  function automatic logic [LONG_W-1:0] place_short(input logic [SHORT_W-1:0] lo);
    return {lo, {(LONG_W-SHORT_W){1'b0}}};
  endfunction

endpackage

// File: rtl/divisor_inmediato.sv
// Combinational split of a constant into a rounded upper part and a signed
// low part such that (hi << 12) + sext(lo) reproduces the constant.
module divisor_inmediato
  import compresor_inmediato_pkg::*;
(
  input  logic [DATA_W-1:0]  valor,
  output logic [LONG_W-1:0]  hi,
  output logic [SHORT_W-1:0] lo,
  output logic               fits,
  output logic               lo_zero
);

  logic [DATA_W-SHORT_W:0] sign_span;

  assign lo        = valor[SHORT_W-1:0];
  assign sign_span = valor[DATA_W-1:SHORT_W-1];

  // A negative lo subtracts from the upper part once extended, so round hi up.
  assign hi      = valor[DATA_W-1:SHORT_W] + LONG_W'(valor[SHORT_W-1]);
  assign fits    = (&sign_span) | ~(|sign_span);
  assign lo_zero = ~(|lo);

endmodule

// File: rtl/compresor_inmediato.sv
// Turns a 32-bit constant into one or two immediate beats for the sign
// extender, with valid/ready handshakes on input and output.
module compresor_inmediato
  import compresor_inmediato_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] valor,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LONG_W-1:0] Inm,
  output logic              InmSrc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  logic [1:0]         state;
  logic [LONG_W-1:0]  beat_inm;
  logic               beat_src;
  logic               beat_last;
  logic [SHORT_W-1:0] lo_hold;

  logic [LONG_W-1:0]  hi;
  logic [SHORT_W-1:0] lo;
  logic               fits;
  logic               lo_zero;
  logic               accept;

  divisor_inmediato u_divisor (
    .valor   (valor),
    .hi      (hi),
    .lo      (lo),
    .fits    (fits),
    .lo_zero (lo_zero)
  );

  assign out_valid = (state != ST_IDLE);
  assign in_ready  = !out_valid || (out_ready && beat_last);
  assign accept    = in_valid && in_ready;

  assign Inm      = beat_inm;
  assign InmSrc   = beat_src;
  assign out_last = beat_last;

  // A new constant takes priority because accept already implies the held beat drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      beat_inm  <= '0;
      beat_src  <= 1'b0;
      beat_last <= 1'b0;
      lo_hold   <= '0;
    end else if (accept) begin
      lo_hold <= lo;
      if (fits) begin
        state     <= ST_ONE;
        beat_inm  <= place_short(lo);
        beat_src  <= 1'b0;
        beat_last <= 1'b1;
      end else if (lo_zero) begin
        state     <= ST_ONE;
        beat_inm  <= hi;
        beat_src  <= 1'b1;
        beat_last <= 1'b1;
      end else begin
        state     <= ST_HI;
        beat_inm  <= hi;
        beat_src  <= 1'b1;
        beat_last <= 1'b0;
      end
    end else if (out_ready) begin
      case (state)
        ST_HI: begin
          state     <= ST_LO;
          beat_inm  <= place_short(lo_hold);
          beat_src  <= 1'b0;
          beat_last <= 1'b1;
        end
        ST_ONE, ST_LO: begin
          state     <= ST_IDLE;
          beat_inm  <= '0;
          beat_src  <= 1'b0;
          beat_last <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
